// File: rtl/preg_free_list.sv
// Free list of physical registers for the rename stage: a circular FIFO of
// non-architectural pregs with speculative head, committed head and tail.
module preg_free_list #(
  parameter int FRONTEND_WIDTH = 2,
  parameter int PHYS_REGS_SIZE = 64,
  parameter int ARCH_REGS      = 32,
  localparam int PRA   = $clog2(PHYS_REGS_SIZE),
  localparam int DEPTH = PHYS_REGS_SIZE - ARCH_REGS,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = IW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FRONTEND_WIDTH-1:0]     alloc_valid_i,
  output logic                          alloc_ready_o,
  output logic [FRONTEND_WIDTH*PRA-1:0] alloc_preg_o,
  input  logic [FRONTEND_WIDTH-1:0]     free_valid_i,
  input  logic [FRONTEND_WIDTH*PRA-1:0] free_preg_i,
  input  logic [FRONTEND_WIDTH-1:0]     commit_alloc_i,
  input  logic                          flush_i,
  output logic [CW-1:0]                 free_count_o,
  output logic                          error_o
);

  logic [PRA-1:0] fifo_q [DEPTH];
  logic [PRA-1:0] fifo_d [DEPTH];

  // Pointers carry a wrap bit above the index so full and empty are distinct.
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] commit_head_q, commit_head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;

  logic [CW-1:0] n_req, n_free, n_commit;
  logic [CW-1:0] inflight;
  logic [IW-1:0] alloc_off [FRONTEND_WIDTH];
  logic [IW-1:0] free_off  [FRONTEND_WIDTH];
  logic [IW-1:0] rd_idx    [FRONTEND_WIDTH];
  logic [IW-1:0] wr_idx    [FRONTEND_WIDTH];
  logic          grant;

  // Exclusive prefix counts compact the requesting lanes onto consecutive slots.
  always_comb begin
    n_req    = '0;
    n_free   = '0;
    n_commit = '0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      alloc_off[i] = n_req[IW-1:0];
      free_off[i]  = n_free[IW-1:0];
      n_req    = n_req    + CW'(alloc_valid_i[i]);
      n_free   = n_free   + CW'(free_valid_i[i]);
      n_commit = n_commit + CW'(commit_alloc_i[i]);
    end
  end

  assign alloc_ready_o = (count_q >= n_req) && !flush_i;
  assign grant         = alloc_ready_o && (|alloc_valid_i);

  generate
    for (genvar gi = 0; gi < FRONTEND_WIDTH; gi++) begin : g_lane
      assign rd_idx[gi] = head_q[IW-1:0] + alloc_off[gi];
      assign wr_idx[gi] = tail_q[IW-1:0] + free_off[gi];
      assign alloc_preg_o[gi*PRA +: PRA] = fifo_q[rd_idx[gi]];
    end
  endgenerate

  always_comb begin
    fifo_d = fifo_q;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      if (free_valid_i[i]) begin
        fifo_d[wr_idx[i]] = free_preg_i[i*PRA +: PRA];
      end
    end
    tail_d        = tail_q + n_free;
    commit_head_d = commit_head_q + n_commit;

    // A flush rewinds to the committed point, including this cycle's commits.
    if (flush_i) begin
      head_d = commit_head_d;
    end else if (grant) begin
      head_d = head_q + n_req;
    end else begin
      head_d = head_q;
    end

    count_d  = tail_d - head_d;
    inflight = head_q - commit_head_q;
    error_d  = error_q || (count_d > CW'(DEPTH)) || (n_commit > inflight);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= PRA'(ARCH_REGS + i);
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= CW'(DEPTH);
      count_q       <= CW'(DEPTH);
      error_q       <= 1'b0;
    end else begin
      for (int i = 0; i < FRONTEND_WIDTH; i++) begin
        assert (!(free_valid_i[i] && (free_preg_i[i*PRA +: PRA] < PRA'(ARCH_REGS))));
      end
      fifo_q        <= fifo_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      error_q       <= error_d;
    end
  end

  assign free_count_o = count_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: a queue-based model of the free list is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_preg_free_list;
  localparam int PRA = 6;
  localparam int CW  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        alloc_valid_i = '0;
  logic              alloc_ready_o;
  logic [2*PRA-1:0]  alloc_preg_o;
  logic [1:0]        free_valid_i = '0;
  logic [2*PRA-1:0]  free_preg_i = '0;
  logic [1:0]        commit_alloc_i = '0;
  logic              flush_i = 1'b0;
  logic [CW-1:0]     free_count_o;
  logic              error_o;

  preg_free_list dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_preg_o   (alloc_preg_o),
    .free_valid_i   (free_valid_i),
    .free_preg_i    (free_preg_i),
    .commit_alloc_i (commit_alloc_i),
    .flush_i        (flush_i),
    .free_count_o   (free_count_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: free_q holds grantable pregs in order, spec_q holds uncommitted grants.
  int free_q[$];
  int spec_q[$];
  bit err_m;
  int m_nreq, m_nc;
  bit m_grant;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q = {};
      spec_q = {};
      for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
      err_m = 1'b0;
    end else begin
      m_nreq  = $countones(alloc_valid_i);
      m_nc    = $countones(commit_alloc_i);
      m_grant = (free_q.size() >= m_nreq) && !flush_i && (m_nreq > 0);
      if (spec_q.size() < m_nc) err_m = 1'b1;
      for (int i = 0; i < m_nc; i++) if (spec_q.size() > 0) void'(spec_q.pop_front());
      if (m_grant) for (int i = 0; i < m_nreq; i++) spec_q.push_back(free_q.pop_front());
      for (int i = 0; i < 2; i++)
        if (free_valid_i[i]) free_q.push_back(int'(free_preg_i[i*PRA +: PRA]));
      if (flush_i) while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
      if (free_q.size() > 32) err_m = 1'b1;
    end
  end

  int  c_idx;
  bit  c_ready;
  always @(negedge clk) begin
    if (!rst) begin
      c_ready = (free_q.size() >= $countones(alloc_valid_i)) && !flush_i;
      chk("model_ready", alloc_ready_o, c_ready);
      chk("model_count", free_count_o, free_q.size());
      chk("model_error", error_o, err_m);
      if (c_ready) begin
        c_idx = 0;
        for (int i = 0; i < 2; i++) begin
          if (alloc_valid_i[i]) begin
            chk("model_preg", alloc_preg_o[i*PRA +: PRA], free_q[c_idx]);
            c_idx++;
          end
        end
      end
    end
  end

  task automatic apply(input logic [1:0] av, input logic [1:0] fv, input int p0, input int p1,
                       input logic [1:0] ca, input logic fl);
    @(posedge clk); #1;
    alloc_valid_i  = av;
    free_valid_i   = fv;
    free_preg_i    = {6'(p1), 6'(p0)};
    commit_alloc_i = ca;
    flush_i        = fl;
  endtask

  task automatic idle();
    apply(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    alloc_valid_i = '0; free_valid_i = '0; free_preg_i = '0;
    commit_alloc_i = '0; flush_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, then drain with both lanes
    do_reset();
    idle(); peek();
    chk("rst_count", free_count_o, 32);
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_error", error_o, 0);
    chk("rst_preg0", alloc_preg_o[5:0], 32);
    for (int k = 0; k < 16; k++) begin
      apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); peek();
      chk("drain_ready", alloc_ready_o, 1);
      chk("drain_lane0", alloc_preg_o[5:0], 32 + 2 * k);
      chk("drain_lane1", alloc_preg_o[11:6], 33 + 2 * k);
    end
    apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("empty_ready", alloc_ready_o, 0);
    chk("empty_count", free_count_o, 0);

    // Lone lane-1 request is compacted onto the head entry
    do_reset();
    apply(2'b10, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("lone1_preg", alloc_preg_o[11:6], 32);
    apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("pair_lane0", alloc_preg_o[5:0], 33);
    chk("pair_lane1", alloc_preg_o[11:6], 34);
    idle(); peek();
    chk("pair_count", free_count_o, 29);

    // Free into an empty list: no bypass, visible next cycle, wrap without error
    do_reset();
    for (int k = 0; k < 16; k++) apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    apply(2'b01, 2'b01, 40, 0, 2'b00, 1'b0); peek();
    chk("nobypass_ready", alloc_ready_o, 0);
    chk("nobypass_count", free_count_o, 0);
    apply(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("refill_ready", alloc_ready_o, 1);
    chk("refill_preg", alloc_preg_o[5:0], 40);
    chk("refill_count", free_count_o, 1);
    idle(); peek();
    chk("wrap_count", free_count_o, 0);
    chk("wrap_error", error_o, 0);

    // Flush rewinds to the committed head
    do_reset();
    for (int k = 0; k < 3; k++) apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    apply(2'b00, 2'b00, 0, 0, 2'b11, 1'b0); peek();
    chk("spec_count", free_count_o, 26);
    apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b1); peek();
    chk("flush_ready", alloc_ready_o, 0);
    idle(); peek();
    chk("flush_count", free_count_o, 30);
    apply(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("flush_next", alloc_preg_o[5:0], 34);
    apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    apply(2'b00, 2'b00, 0, 0, 2'b01, 1'b1);
    idle(); peek();
    chk("flushc_count", free_count_o, 29);
    apply(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("flushc_next", alloc_preg_o[5:0], 35);

    // Release into a full list is an overflow and the flag is sticky
    do_reset();
    apply(2'b00, 2'b01, 45, 0, 2'b00, 1'b0);
    idle(); peek();
    chk("ovf_error", error_o, 1);
    repeat (3) idle();
    peek();
    chk("ovf_sticky", error_o, 1);
    do_reset();
    idle(); peek();
    chk("ovf_cleared", error_o, 0);

    // Simultaneous alloc/free, then asynchronous reset mid-cycle
    do_reset();
    for (int k = 0; k < 4; k++) apply(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    apply(2'b11, 2'b11, 32, 33, 2'b00, 1'b0); peek();
    chk("simul_lane0", alloc_preg_o[5:0], 40);
    chk("simul_lane1", alloc_preg_o[11:6], 41);
    chk("simul_before", free_count_o, 24);
    apply(2'b00, 2'b01, 34, 0, 2'b00, 1'b0); peek();
    chk("simul_after", free_count_o, 24);
    apply(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); peek();
    chk("mid_count", free_count_o, 25);
    chk("mid_preg", alloc_preg_o[5:0], 42);
    rst = 1'b1;
    #1;
    chk("arst_count", free_count_o, 32);
    chk("arst_preg0", alloc_preg_o[5:0], 32);
    chk("arst_error", error_o, 0);
    chk("arst_ready", alloc_ready_o, 1);
    @(posedge clk); #1;
    alloc_valid_i = '0;
    rst = 1'b0;
    idle(); peek();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
